// File: rtl/inst_encode_unit.sv
// -----------------------------------------------------------------------------
// inst_encode_unit
//
// Streaming RV32I instruction encoder. Packs opcode, register indices, funct
// fields and a 32-bit byte-offset immediate into one instruction word, which is
// the inverse of immediate extraction. One word is emitted per accepted request
// over a run of len_i words. The k-th word of a run carries write address
// base + 4*k, which wraps modulo 2^ADDR_WIDTH.
//
// Optional build macro: ENCODER_RANGE_CHECK_EN
//   Defined   : out_err_o flags an immediate that is out of range or misaligned
//               for its format, or an unknown opcode. err_cnt_o counts flagged
//               words at output handshake and saturates at all-ones.
//   Undefined : out_err_o and err_cnt_o are tied to zero.
//
// Ports
//   clk_i, rst_ni          clock; asynchronous active-low reset
//   start_i                start a run (sampled only while idle)
//   base_addr_i, len_i     first byte address and word count, latched on start
//   in_valid_i/in_ready_o  request handshake
//   op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i   instruction fields
//   out_valid_o/out_ready_i output handshake (one-deep output register)
//   out_inst_o, out_addr_o encoded word and its write address
//   out_err_o, err_cnt_o   range-check flag and saturating error count
//   busy_o, done_o         run in progress; one-cycle end-of-run pulse
// -----------------------------------------------------------------------------
module inst_encode_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int REG_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [6:0]            op_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [REG_WIDTH-1:0]  imm_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [REG_WIDTH-1:0]  out_inst_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic                  out_err_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    rem_q, rem_d;
    logic                    out_valid_q, out_valid_d;
    logic [REG_WIDTH-1:0]    out_inst_q, out_inst_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic [REG_WIDTH-1:0]    enc_word;
    logic                    accept;
    logic                    handshake;

    assign in_ready_o  = (state_q == S_ACTIVE) && (!out_valid_q || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign handshake   = out_valid_q && out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_inst_o  = out_inst_q;
    assign out_addr_o  = out_addr_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

    // Immediate scatter; unknown opcodes fall back to R-type packing.
    always_comb begin
        enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
        case (op_i)
            OP_LUI, OP_AUIPC:
                enc_word = {imm_i[31:12], rd_i, op_i};
            OP_JAL:
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
            OP_BRANCH:
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], op_i};
            OP_STORE:
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
            OP_JALR, OP_LOAD, OP_ALUI:
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;

        if (handshake) begin
            out_valid_d = 1'b0;
        end
        // A same-cycle accept refills the register the handshake just freed.
        if (accept) begin
            out_valid_d = 1'b1;
            out_inst_d  = enc_word;
            out_addr_d  = addr_q;
            addr_d      = addr_q + ADDR_WIDTH'(4);
            rem_d       = rem_q - CNT_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d = base_addr_i;
                    rem_d  = len_i;
                    if (len_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (accept && rem_q == CNT_WIDTH'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
        end
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic                 enc_err;
    logic                 out_err_q, out_err_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 fits_i12, fits_b13, fits_j21;

    // Sign-extension checks: the discarded upper bits must all equal the
    // top bit kept by the format.
    assign fits_i12 = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign fits_b13 = (&imm_i[31:12]) || !(|imm_i[31:12]);
    assign fits_j21 = (&imm_i[31:20]) || !(|imm_i[31:20]);

    always_comb begin
        enc_err = 1'b0;
        case (op_i)
            OP_LUI, OP_AUIPC:                    enc_err = (imm_i[11:0] != '0);
            OP_JAL:                              enc_err = !fits_j21 || imm_i[0];
            OP_BRANCH:                           enc_err = !fits_b13 || imm_i[0];
            OP_STORE, OP_JALR, OP_LOAD, OP_ALUI: enc_err = !fits_i12;
            OP_ALU:                              enc_err = 1'b0;
            default:                             enc_err = 1'b1;
        endcase
    end

    always_comb begin
        out_err_d = out_err_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            out_err_d = enc_err;
        end
        if (handshake && out_err_q && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
        if (state_q == S_IDLE && start_i) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            out_err_q <= out_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_err_o = out_err_q;
    assign err_cnt_o = err_cnt_q;
`else
    assign out_err_o = 1'b0;
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_encode_unit.sv
module tb_inst_encode_unit;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

`ifdef ENCODER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] len_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [6:0]  op_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_inst_o;
    logic [31:0] out_addr_o;
    logic        out_err_o;
    logic [15:0] err_cnt_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_fail   = 0;

    inst_encode_unit #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_inst_o(out_inst_o), .out_addr_o(out_addr_o),
        .out_err_o(out_err_o), .err_cnt_o(err_cnt_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_enc(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
        logic [31:0] regs;
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        case (op)
            OP_LUI, OP_AUIPC:
                return 32'(op) | (imm & 32'hFFFF_F000) | (32'(rd) << 7);
            OP_JAL:
                return 32'(op) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                     | (32'(rd) << 7);
            OP_BRANCH:
                return 32'(op) | regs | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            OP_STORE:
                return 32'(op) | regs | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            OP_JALR, OP_LOAD, OP_ALUI:
                return 32'(op) | (imm << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
            default:
                return 32'(op) | regs | (32'(f7) << 25) | (32'(rd) << 7);
        endcase
    endfunction

    function automatic logic m_err(input logic [6:0] op, input logic [31:0] imm);
        int  s;
        logic bad;
        s = $signed(imm);
        case (op)
            OP_LUI, OP_AUIPC:                    bad = (imm % 32'd4096) != 0;
            OP_JAL:                              bad = s < -(1 << 20) || s > (1 << 20) - 1 || imm[0];
            OP_BRANCH:                           bad = s < -4096 || s > 4095 || imm[0];
            OP_STORE, OP_JALR, OP_LOAD, OP_ALUI: bad = s < -2048 || s > 2047;
            OP_ALU:                              bad = 1'b0;
            default:                             bad = 1'b1;
        endcase
        return RANGE_EN && bad;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    bit          m_idle, m_run, m_done;
    int unsigned m_rem, m_errcnt;
    logic [31:0] m_addr;

    always @(negedge clk_i) begin : mon
        bit exp_ready, acc, hs, drain_ok;
        if (!rst_ni) begin
            m_idle = 1; m_run = 0; m_done = 0; m_rem = 0; m_errcnt = 0; m_addr = '0;
            q.delete();
        end else begin
            exp_ready = m_run && m_rem != 0 && (q.size() == 0 || out_ready_i);
            chk("busy", 32'(busy_o), 32'(!m_idle));
            chk("done", 32'(done_o), 32'(m_done));
            chk("in_ready", 32'(in_ready_o), 32'(exp_ready));
            chk("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
            chk("err_cnt", 32'(err_cnt_o), m_errcnt);
            if (q.size() != 0) begin
                chk("inst", out_inst_o, q[0].inst);
                chk("addr", out_addr_o, q[0].addr);
                chk("err", 32'(out_err_o), 32'(q[0].err));
            end
            acc      = in_valid_i && exp_ready;
            hs       = q.size() != 0 && out_ready_i;
            drain_ok = m_run && m_rem == 0 && (q.size() == 0 || out_ready_i);
            if (hs) begin
                if (q[0].err && m_errcnt != 32'hFFFF) m_errcnt++;
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back('{inst: m_enc(op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i),
                              addr: m_addr, err: m_err(op_i, imm_i)});
                m_addr = m_addr + 32'd4;
                m_rem--;
            end
            if (m_done) begin
                m_done = 0; m_idle = 1;
            end else if (m_idle) begin
                if (start_i) begin
                    m_errcnt = 0;
                    m_idle   = 0;
                    if (len_i == 0) m_done = 1;
                    else begin
                        m_run = 1; m_rem = 32'(len_i); m_addr = base_addr_i;
                    end
                end
            end else if (drain_ok) begin
                m_run = 0; m_done = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [15:0] len);
        start_i = 1; base_addr_i = base; len_i = len;
        cyc();
        start_i = 0;
    endtask

    task automatic drive_random();
        logic [6:0] ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                OP_LOAD, OP_STORE, OP_ALUI, OP_ALU};
        logic [31:0] imm;
        in_valid_i  = $urandom_range(0, 3) != 0;
        out_ready_i = $urandom_range(0, 3) != 0;
        start_i     = $urandom_range(0, 15) == 0;
        base_addr_i = $urandom;
        len_i       = 16'($urandom);
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2: imm = $urandom & 32'hFFFF_F000;
            default: imm = (32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000) & ~32'h1;
        endcase
        set_req((($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)]),
                5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                seen = 1;
                break;
            end
            if (rnd) drive_random();
            cyc();
        end
        start_i = 0; in_valid_i = 0;
        chk("run_done", 32'(seen), 32'd1);
        cyc();
    endtask

    // Single-word run with literal expectations.
    task automatic run_lit(input string name, input logic [31:0] base, input logic [31:0] exp_inst,
                           input logic exp_err);
        out_ready_i = 1;
        start_run(base, 16'd1);
        in_valid_i = 1;
        cyc();
        in_valid_i = 0;
        chk({name, "_valid"}, 32'(out_valid_o), 32'd1);
        chk({name, "_inst"}, out_inst_o, exp_inst);
        chk({name, "_addr"}, out_addr_o, base);
        chk({name, "_err"}, 32'(out_err_o), 32'(exp_err));
        cyc();
        chk({name, "_done"}, 32'(done_o), 32'd1);
        cyc();
        chk({name, "_done_end"}, 32'(done_o), 32'd0);
        chk({name, "_busy_end"}, 32'(busy_o), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] held_inst, held_addr;
        logic [31:0] seen_addr[$];
        int          ndone;

        rst_ni = 0; start_i = 0; in_valid_i = 0; out_ready_i = 0;
        base_addr_i = '0; len_i = '0;
        set_req(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        cyc(); cyc();
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_inst", out_inst_o, 32'd0);
        rst_ni = 1;
        cyc();

        set_req(OP_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        run_lit("addi", 32'h100, 32'hFFF0_0093, 1'b0);
        set_req(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        run_lit("jal", 32'h200, 32'h0010_00EF, 1'b0);
        set_req(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        run_lit("beq", 32'h300, 32'hFE20_8EE3, 1'b0);
        set_req(OP_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        run_lit("range", 32'h400, 32'h8000_0093, RANGE_EN);
        chk("err_cnt_after", 32'(err_cnt_o), 32'(RANGE_EN));

        // Zero-length run: also clears the error counter.
        start_run(32'h500, 16'd0);
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_valid", 32'(out_valid_o), 32'd0);
        chk("len0_errcnt", 32'(err_cnt_o), 32'd0);
        cyc();
        chk("len0_done_end", 32'(done_o), 32'd0);
        cyc();

        // Stalled run wrapping the address space.
        out_ready_i = 0;
        start_run(32'hFFFF_FFF8, 16'd3);
        set_req(OP_ALU, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'h0);
        in_valid_i = 1;
        cyc();
        held_inst = out_inst_o;
        held_addr = out_addr_o;
        chk("stall_first_inst", held_inst, 32'h4052_01B3);
        chk("stall_first_addr", held_addr, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 32'(in_ready_o), 32'd0);
            chk("stall_inst_hold", out_inst_o, held_inst);
            chk("stall_addr_hold", out_addr_o, held_addr);
            cyc();
        end
        out_ready_i = 1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_o) seen_addr.push_back(out_addr_o);
            if (done_o) ndone++;
            cyc();
        end
        in_valid_i = 0;
        chk("stall_nwords", 32'(seen_addr.size()), 32'd3);
        if (seen_addr.size() == 3) begin
            chk("stall_addr0", seen_addr[0], 32'hFFFF_FFF8);
            chk("stall_addr1", seen_addr[1], 32'hFFFF_FFFC);
            chk("stall_addr2", seen_addr[2], 32'h0000_0000);
        end
        chk("stall_ndone", 32'(ndone), 32'd1);

        // Asynchronous reset in the middle of a run.
        out_ready_i = 0;
        start_run(32'h40, 16'd5);
        set_req(OP_ALUI, 5'd7, 5'd2, 5'd0, 3'd1, 7'd0, 32'h800);
        in_valid_i = 1;
        cyc();
        #1 rst_ni = 0;
        #1;
        chk("arst_valid", 32'(out_valid_o), 32'd0);
        chk("arst_inst", out_inst_o, 32'd0);
        chk("arst_addr", out_addr_o, 32'd0);
        chk("arst_err", 32'(out_err_o), 32'd0);
        chk("arst_errcnt", 32'(err_cnt_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_in_ready", 32'(in_ready_o), 32'd0);
        in_valid_i = 0;
        cyc();
        rst_ni = 1;
        cyc();
        set_req(OP_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        run_lit("post_rst", 32'h100, 32'hFFF0_0093, 1'b0);

        // Randomized runs checked by the model.
        for (int r = 0; r < 40; r++) begin
            out_ready_i = $urandom_range(0, 1) != 0;
            start_run($urandom, 16'($urandom_range(0, 12)));
            wait_done(1'b1, 600);
        end

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
